// File: rtl/subneg_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// subneg_pkg
// Shared constants and types for the SUBNEG memory subsystem.
//   DW / AW        : data word width and address width
//   SUBNEG_DEPTH   : number of memory words
//   state_t        : arbiter top-level state (CLEAR after reset, then SERVE)
//   PORT_CPU/HOST  : bit positions of each requester in request/grant vectors
// -----------------------------------------------------------------------------
package subneg_pkg;

    localparam int DW           = 6;
    localparam int AW           = 5;
    localparam int SUBNEG_DEPTH = 22;

    localparam int PORT_CPU  = 0;
    localparam int PORT_HOST = 1;

    typedef enum logic {
        CLEAR = 1'b0,
        SERVE = 1'b1
    } state_t;

endpackage

// File: rtl/subneg_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// subneg_mem_arbiter_if
// Bundle of the two requester ports (core and host) plus arbiter status.
//   cpu_*  : core request/write-enable/address/write-data, grant, read return
//   host_* : host request/write-enable/address/write-data, grant, read return
//   host_lock : blocks core grants while high
//   ready     : clear sequence done, arbiter serving
//   addr_err  : one-cycle pulse after a grant with an out-of-range address
// Modports: slave = memory arbiter side, master = requester side.
// -----------------------------------------------------------------------------
interface subneg_mem_arbiter_if #(
    parameter int AW = subneg_pkg::AW,
    parameter int DW = subneg_pkg::DW
);

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;

    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt;
    logic          host_rvalid;
    logic [DW-1:0] host_rdata;

    logic          host_lock;
    logic          ready;
    logic          addr_err;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  host_req, host_we, host_addr, host_wdata,
        output host_gnt, host_rvalid, host_rdata,
        input  host_lock,
        output ready, addr_err
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output host_req, host_we, host_addr, host_wdata,
        input  host_gnt, host_rvalid, host_rdata,
        output host_lock,
        input  ready, addr_err
    );

endinterface

// File: rtl/subneg_mem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// subneg_rr_arb2
// Two-way round-robin arbiter with combinational grant.
//   clk, reset : clock, synchronous active-high reset
//   i_req[1:0] : raw requests (bit PORT_CPU, bit PORT_HOST)
//   i_mask[1:0]: 1 = requester not eligible this cycle
//   o_gnt[1:0] : one-hot (or zero) grant for the current cycle
// The last-granted pointer resets to the host so the core wins the first tie,
// and it only moves when a grant is actually issued.
// -----------------------------------------------------------------------------
module subneg_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic [1:0] i_mask,
    output logic [1:0] o_gnt
);
    import subneg_pkg::*;

    logic       r_last;
    logic [1:0] w_elig;

    always_comb begin
        w_elig = i_req & ~i_mask;
        o_gnt  = w_elig;
        // On a tie, favour whichever port was not served most recently.
        if (w_elig == 2'b11) begin
            o_gnt = r_last ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= 1'(PORT_HOST);
        end else if (|o_gnt) begin
            r_last <= o_gnt[PORT_HOST];
        end
    end

endmodule

// File: rtl/subneg_mem_arbiter.sv
// -----------------------------------------------------------------------------
// subneg_mem_arbiter
// Owns the shared SUBNEG program/data memory. After reset it zeroes every word
// (CLEAR), then serves at most one core or host access per cycle (SERVE).
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset
//   bus   : subneg_mem_arbiter_if.slave -- both requester ports, host_lock,
//           ready and addr_err
// Reads return registered data with rvalid one cycle after the grant.
// Out-of-range accesses are granted, writes are dropped, reads return 0 and
// addr_err pulses the cycle after the grant.
// -----------------------------------------------------------------------------
module subneg_mem_arbiter #(
    parameter int DEPTH = subneg_pkg::SUBNEG_DEPTH,
    parameter int AW    = subneg_pkg::AW,
    parameter int DW    = subneg_pkg::DW
) (
    input  logic                clk,
    input  logic                reset,
    subneg_mem_arbiter_if.slave bus
);
    import subneg_pkg::*;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt_nxt;
    logic          w_clr_we;
    logic          w_serve;

    logic [DW-1:0] r_mem [DEPTH];

    logic [1:0]    w_req;
    logic [1:0]    w_mask;
    logic [1:0]    w_gnt;
    logic          w_cpu_gnt;
    logic          w_host_gnt;

    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;
    logic          w_in_range;
    logic [DW-1:0] w_rd_word;

    logic          r_cpu_rvalid;
    logic          r_host_rvalid;
    logic [DW-1:0] r_cpu_rdata;
    logic [DW-1:0] r_host_rdata;
    logic          r_addr_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Counter stops at the last word rather than wrapping, so DEPTH == 2**AW
    // also terminates correctly.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_clr_we    = 1'b0;
        w_serve     = 1'b0;
        unique case (r_state)
            CLEAR: begin
                w_clr_we = 1'b1;
                if (r_cnt == LAST_ADDR) begin
                    w_state_nxt = SERVE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            SERVE: begin
                w_serve = 1'b1;
            end
            default: begin
                w_state_nxt = CLEAR;
            end
        endcase
    end

    // Nobody is eligible outside SERVE; host_lock removes the core immediately.
    assign w_req  = {bus.host_req, bus.cpu_req};
    assign w_mask = {~w_serve, ~w_serve | bus.host_lock};

    subneg_rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .i_req  (w_req),
        .i_mask (w_mask),
        .o_gnt  (w_gnt)
    );

    assign w_cpu_gnt  = w_gnt[PORT_CPU];
    assign w_host_gnt = w_gnt[PORT_HOST];

    always_comb begin
        w_we    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        if (w_host_gnt) begin
            w_we    = bus.host_we;
            w_addr  = bus.host_addr;
            w_wdata = bus.host_wdata;
        end else if (w_cpu_gnt) begin
            w_we    = bus.cpu_we;
            w_addr  = bus.cpu_addr;
            w_wdata = bus.cpu_wdata;
        end
    end

    assign w_in_range = (32'(w_addr) < DEPTH);
    assign w_rd_word  = w_in_range ? r_mem[w_addr] : '0;

    // A reset edge blocks any write that happens to be granted in that cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_clr_we) begin
                r_mem[r_cnt] <= '0;
            end else if ((|w_gnt) && w_we && w_in_range) begin
                r_mem[w_addr] <= w_wdata;
            end
        end
    end

    // rdata is only loaded on a read grant to that port, so it holds otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cpu_rvalid  <= 1'b0;
            r_host_rvalid <= 1'b0;
            r_cpu_rdata   <= '0;
            r_host_rdata  <= '0;
            r_addr_err    <= 1'b0;
        end else begin
            r_cpu_rvalid  <= w_cpu_gnt && !bus.cpu_we;
            r_host_rvalid <= w_host_gnt && !bus.host_we;
            r_addr_err    <= (|w_gnt) && !w_in_range;
            if (w_cpu_gnt && !bus.cpu_we) begin
                r_cpu_rdata <= w_rd_word;
            end
            if (w_host_gnt && !bus.host_we) begin
                r_host_rdata <= w_rd_word;
            end
        end
    end

    assign bus.cpu_gnt     = w_cpu_gnt;
    assign bus.host_gnt    = w_host_gnt;
    assign bus.cpu_rvalid  = r_cpu_rvalid;
    assign bus.host_rvalid = r_host_rvalid;
    assign bus.cpu_rdata   = r_cpu_rdata;
    assign bus.host_rdata  = r_host_rdata;
    assign bus.addr_err    = r_addr_err;
    assign bus.ready       = (r_state == SERVE);

endmodule
